// File: rtl/tree_node_merge_arb.sv
// Five-to-one round-robin merge node with a one-entry registered output stage.
// Define TREE_MERGE_LOCK_EN to hold the grant on one child until it sends in_last.
module tree_node_merge_arb #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 5,
  parameter int SRC_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid_i,
  input  logic [N_CH*DATA_W-1:0]   in_data_i,
  input  logic [N_CH-1:0]          in_last_i,
  output logic [N_CH-1:0]          in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [SRC_W-1:0]         out_src_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SRC_W-1:0]  out_src_q;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              load, accept, gnt_vld;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W:0]    idx;
  logic [N_CH-1:0]   gnt_oh;
  logic [DATA_W-1:0] sel_data;

`ifdef TREE_MERGE_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t            state_q;
  logic [SRC_W-1:0]  lock_ch_q;
  logic              out_last_q;
`else
  logic unused_last;
  assign unused_last = ^in_last_i;
`endif

  assign load = !out_valid_q || out_ready_i;

  // Search from ptr upward with wrap; the first valid child wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(N_CH)) idx = idx - (SRC_W+1)'(N_CH);
      if (!gnt_vld && in_valid_i[idx[SRC_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[SRC_W-1:0];
      end
    end
`ifdef TREE_MERGE_LOCK_EN
    if (state_q == LOCKED) begin
      gnt_vld = in_valid_i[lock_ch_q];
      gnt_idx = lock_ch_q;
    end
`endif
  end

  always_comb begin
    gnt_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt_oh[i] = (gnt_idx == SRC_W'(i));
      if (gnt_idx == SRC_W'(i)) sel_data = in_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign accept     = load && gnt_vld && !rst;
  assign in_ready_o = accept ? gnt_oh : '0;
  assign ptr_d      = (gnt_idx == SRC_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
`ifdef TREE_MERGE_LOCK_EN
      out_last_q  <= 1'b0;
      state_q     <= IDLE;
      lock_ch_q   <= '0;
`endif
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_src_q   <= gnt_idx;
`ifdef TREE_MERGE_LOCK_EN
        out_last_q  <= in_last_i[gnt_idx];
`endif
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
`ifdef TREE_MERGE_LOCK_EN
      // ptr only moves when a packet ends, so it stays frozen while locked.
      case (state_q)
        IDLE: if (accept) begin
          if (in_last_i[gnt_idx]) ptr_q <= ptr_d;
          else begin
            state_q   <= LOCKED;
            lock_ch_q <= gnt_idx;
          end
        end
        LOCKED: if (accept && in_last_i[gnt_idx]) begin
          state_q <= IDLE;
          ptr_q   <= ptr_d;
        end
        default: state_q <= IDLE;
      endcase
`else
      if (accept) ptr_q <= ptr_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
`ifdef TREE_MERGE_LOCK_EN
  assign out_last_o  = out_last_q;
`else
  assign out_last_o  = 1'b0;
`endif

endmodule

// File: tb/tb_tree_node_merge_arb.sv
// Directed bench for tree_node_merge_arb: table rows plus hand sequences for
// backpressure and mid-operation reset.
module tb_tree_node_merge_arb;

  localparam int DATA_W = 32;
  localparam int N_CH   = 5;
`ifdef TREE_MERGE_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        in_valid, in_last, in_ready;
  logic [N_CH*DATA_W-1:0] in_data;
  logic                   out_valid, out_last, out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [2:0]             out_src;

  int n_chk = 0;
  int n_fail = 0;

  tree_node_merge_arb #(.DATA_W(DATA_W), .N_CH(N_CH), .SRC_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
    .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_src_o(out_src),
    .out_last_o(out_last), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] vld;
    logic [4:0] last;
    logic       ordy;
    logic [4:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_src;
    logic       exp_last;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic [4:0] v, logic [4:0] l, logic o, logic [4:0] r,
                              logic ov, logic [2:0] s, logic el);
    vec_t t;
    t.vld = v; t.last = l; t.ordy = o; t.exp_rdy = r;
    t.exp_ov = ov; t.exp_src = s; t.exp_last = el;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N_CH; i++) in_data[i*DATA_W +: DATA_W] = 32'h100 + i;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      @(negedge clk);
      in_valid  = tbl[r].vld;
      in_last   = tbl[r].last;
      out_ready = tbl[r].ordy;
      #1 chk($sformatf("row%0d in_ready", r), 32'(in_ready), 32'(tbl[r].exp_rdy));
      @(posedge clk);
      #1 chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
      if (tbl[r].exp_ov) begin
        chk($sformatf("row%0d out_src", r), 32'(out_src), 32'(tbl[r].exp_src));
        chk($sformatf("row%0d out_data", r), out_data, 32'h100 + 32'(tbl[r].exp_src));
        chk($sformatf("row%0d out_last", r), 32'(out_last), 32'(tbl[r].exp_last));
      end
    end
  endtask

  initial begin
    // Fairness from reset: all valid, single-beat packets, one beat per cycle.
    for (int k = 0; k < 6; k++)
      tbl[k] = mk(5'b11111, 5'b11111, 1, 5'(1 << (k % 5)), 1, 3'(k % 5), LK);
    tbl[6]  = mk(5'b00000, 5'b11111, 1, 5'b00000, 0, 0, 0);
    // ptr=1: ch3 alone moves ptr to 4, then ch1/ch3 alternate with wrap.
    tbl[7]  = mk(5'b01000, 5'b11111, 1, 5'b01000, 1, 3, LK);
    tbl[8]  = mk(5'b01010, 5'b11111, 1, 5'b00010, 1, 1, LK);
    tbl[9]  = mk(5'b01010, 5'b11111, 1, 5'b01000, 1, 3, LK);
    tbl[10] = mk(5'b01010, 5'b11111, 1, 5'b00010, 1, 1, LK);
    tbl[11] = mk(5'b00000, 5'b11111, 1, 5'b00000, 0, 0, 0);
    // ch1 three-beat packet while ch0 stays valid, starting at ptr=1.
`ifdef TREE_MERGE_LOCK_EN
    tbl[12] = mk(5'b00011, 5'b00000, 1, 5'b00010, 1, 1, 0);
    tbl[13] = mk(5'b00011, 5'b00000, 1, 5'b00010, 1, 1, 0);
    tbl[14] = mk(5'b00011, 5'b00010, 1, 5'b00010, 1, 1, 1);
    tbl[15] = mk(5'b00001, 5'b00001, 1, 5'b00001, 1, 0, 1);
`else
    tbl[12] = mk(5'b00011, 5'b00000, 1, 5'b00010, 1, 1, 0);
    tbl[13] = mk(5'b00011, 5'b00000, 1, 5'b00001, 1, 0, 0);
    tbl[14] = mk(5'b00011, 5'b00010, 1, 5'b00010, 1, 1, 0);
    tbl[15] = mk(5'b00011, 5'b00000, 1, 5'b00001, 1, 0, 0);
`endif
    tbl[16] = mk(5'b00000, 5'b11111, 1, 5'b00000, 0, 0, 0);

    set_default_data();
    in_last   = 5'b11111;
    in_valid  = 5'b11111;
    out_ready = 1'b1;
    rst       = 1'b1;

    // Reset: in_ready low even with everything valid and the output free.
    repeat (2) begin
      @(negedge clk);
      #1 chk("rst in_ready", 32'(in_ready), 0);
    end
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_src", 32'(out_src), 0);
    chk("rst out_last", 32'(out_last), 0);
    in_valid = '0;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 chk("idle out_valid", 32'(out_valid), 0);
    end

    run_rows(0, 11);

    // Backpressure: ptr=2, ch2 beat held for 4 stalled cycles, delivered once.
    @(negedge clk);
    in_data[2*DATA_W +: DATA_W] = 32'hA5A5;
    in_valid = 5'b00100;
    out_ready = 1'b0;
    #1 chk("bp accept in_ready", 32'(in_ready), 32'b00100);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 5'b11111;
      #1 chk("bp stall in_ready", 32'(in_ready), 0);
      chk("bp stall out_valid", 32'(out_valid), 1);
      chk("bp stall out_data", out_data, 32'hA5A5);
      chk("bp stall out_src", 32'(out_src), 2);
    end
    @(negedge clk);
    in_valid = '0;
    out_ready = 1'b1;
    set_default_data();
    #1 chk("bp drain out_valid", 32'(out_valid), 1);
    repeat (2) begin
      @(posedge clk);
      #1 chk("bp no dup out_valid", 32'(out_valid), 0);
    end

    // Mid-operation reset: ptr=3, ch3 beat buffered and stalled, then reset.
    @(negedge clk);
    in_valid = 5'b01000;
    out_ready = 1'b0;
    #1 chk("mr accept in_ready", 32'(in_ready), 32'b01000);
    @(negedge clk);
    in_valid = '0;
    rst = 1'b1;
    #1 chk("mr held out_valid", 32'(out_valid), 1);
    chk("mr rst in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 chk("mr flushed out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 5'b11111;
    out_ready = 1'b1;
    #1 chk("mr ptr0 in_ready", 32'(in_ready), 32'b00001);
    @(posedge clk);
    #1 chk("mr out_src", 32'(out_src), 0);
    chk("mr out_data", out_data, 32'h100);

    // ptr=1 now: packet lock / per-beat interleave.
    run_rows(12, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
